// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the UART clocking blocks.
//   UART_CNT_W       - width of the divisor and the oversample counter
//   UART_OVERSAMPLE  - oversample ticks per baud period
//   UART_DEFAULT_DIV - reset divisor: 100 MHz / 16 / 230400 ~= 27
package uart_pkg;

    localparam int UART_CNT_W       = 16;
    localparam int UART_OVERSAMPLE  = 16;
    localparam int UART_DEFAULT_DIV = 27;

endpackage

// File: rtl/tick_counter.sv
// tick_counter: wrapping up-counter with synchronous clear.
//   clk  in  - clock
//   rst  in  - synchronous active-high reset
//   inc  in  - advance the count this cycle
//   clr  in  - force the count to zero (beats inc)
//   max  in  - terminal value; the count returns to zero after it
//   cnt  out - current count
//   wrap out - inc is asserted and the count is at (or past) max
module tick_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    input  logic [W-1:0] max,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // ">=" rather than "==": a divisor shrunk while idle can leave the count
    // above the new terminal value, and it must still return to zero.
    assign wrap = inc && (cnt_q >= max);
    assign cnt  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (wrap) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/baud_gen.sv
// baud_gen: programmable baud-rate generator.
//   inp_clk     in  - system clock
//   rst         in  - synchronous active-high reset
//   en          in  - count enable
//   sync_clr    in  - realign phase: clears both counters
//   div_wr      in  - one-cycle write strobe for div_val
//   div_val     in  - new divisor (inp_clk cycles per oversample tick)
//   os_tick     out - one-cycle pulse per oversample period
//   baud_tick   out - one-cycle pulse per baud period
//   out_clk     out - baud-rate square wave (low first half, high second)
//   div_pending out - a written divisor is waiting to be applied
module baud_gen
    import uart_pkg::*;
#(
    parameter int CNT_W       = UART_CNT_W,
    parameter int OVERSAMPLE  = UART_OVERSAMPLE,
    parameter int DEFAULT_DIV = UART_DEFAULT_DIV
) (
    input  logic             inp_clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync_clr,
    input  logic             div_wr,
    input  logic [CNT_W-1:0] div_val,
    output logic             os_tick,
    output logic             baud_tick,
    output logic             out_clk,
    output logic             div_pending
);

    localparam int PH_W = $clog2(OVERSAMPLE);

    logic [CNT_W-1:0] div_act_q, div_act_d;
    logic [CNT_W-1:0] div_shd_q, div_shd_d;
    logic             div_pending_q, div_pending_d;
    logic             os_tick_q, baud_tick_q, out_clk_q, out_clk_d;

    logic [CNT_W-1:0] os_max;
    logic [CNT_W-1:0] os_cnt;
    logic [PH_W-1:0]  ph_cnt;
    logic [PH_W-1:0]  ph_next;
    logic             counting, os_wrap, ph_wrap, apply;

    assign counting = en && !sync_clr;

    // A divisor of 0 behaves as 1.
    assign os_max = (div_act_q == '0) ? '0 : div_act_q - CNT_W'(1);

    tick_counter #(.W(CNT_W)) u_os_cnt (
        .clk  (inp_clk),
        .rst  (rst),
        .inc  (counting),
        .clr  (sync_clr),
        .max  (os_max),
        .cnt  (os_cnt),
        .wrap (os_wrap)
    );

    tick_counter #(.W(PH_W)) u_ph_cnt (
        .clk  (inp_clk),
        .rst  (rst),
        .inc  (os_wrap),
        .clr  (sync_clr),
        .max  (PH_W'(OVERSAMPLE - 1)),
        .cnt  (ph_cnt),
        .wrap (ph_wrap)
    );

    // OVERSAMPLE is a power of two, so the natural PH_W-bit wrap is mod OVERSAMPLE.
    assign ph_next = os_wrap ? ph_cnt + PH_W'(1) : ph_cnt;

    // The shadow is only promoted where the counter is at a period boundary or frozen.
    assign apply = os_wrap || sync_clr || !en;

    always_comb begin
        div_act_d     = div_act_q;
        div_shd_d     = div_shd_q;
        div_pending_d = div_pending_q;
        if (apply) begin
            div_pending_d = 1'b0;
            if (div_wr) begin
                div_act_d = div_val;
                div_shd_d = div_val;
            end else begin
                div_act_d = div_shd_q;
            end
        end else if (div_wr) begin
            div_shd_d     = div_val;
            div_pending_d = 1'b1;
        end
    end

    always_comb begin
        out_clk_d = out_clk_q;
        if (sync_clr) begin
            out_clk_d = 1'b0;
        end else if (en) begin
            out_clk_d = (ph_next >= PH_W'(OVERSAMPLE / 2));
        end
    end

    always_ff @(posedge inp_clk) begin
        if (rst) begin
            div_act_q     <= CNT_W'(DEFAULT_DIV);
            div_shd_q     <= CNT_W'(DEFAULT_DIV);
            div_pending_q <= 1'b0;
            os_tick_q     <= 1'b0;
            baud_tick_q   <= 1'b0;
            out_clk_q     <= 1'b0;
        end else begin
            div_act_q     <= div_act_d;
            div_shd_q     <= div_shd_d;
            div_pending_q <= div_pending_d;
            os_tick_q     <= os_wrap;
            baud_tick_q   <= ph_wrap;
            out_clk_q     <= out_clk_d;
        end
    end

    assign os_tick     = os_tick_q;
    assign baud_tick   = baud_tick_q;
    assign out_clk     = out_clk_q;
    assign div_pending = div_pending_q;

endmodule

// File: tb/tb_baud_gen.sv
module tb_baud_gen;

    localparam int OS   = 16;
    localparam int DDEF = 27;

    logic        inp_clk = 1'b0;
    logic        rst = 1'b1, en = 1'b0, sync_clr = 1'b0, div_wr = 1'b0;
    logic [15:0] div_val = '0;
    logic        os_tick, baud_tick, out_clk, div_pending;

    always #5 inp_clk = ~inp_clk;

    baud_gen dut (
        .inp_clk     (inp_clk),
        .rst         (rst),
        .en          (en),
        .sync_clr    (sync_clr),
        .div_wr      (div_wr),
        .div_val     (div_val),
        .os_tick     (os_tick),
        .baud_tick   (baud_tick),
        .out_clk     (out_clk),
        .div_pending (div_pending)
    );

    int     n_cmp = 0;
    int     n_err = 0;
    string  phase = "reset";
    logic [3:0] exp_q[$];

    // Behavioural reference: plain integers following the block's rules.
    int m_os, m_ph, m_act, m_shd;
    bit m_pend, m_ost, m_bt, m_oc;

    task automatic model_step();
        int d;
        bit wrap, apply;
        if (rst) begin
            m_os = 0; m_ph = 0; m_act = DDEF; m_shd = DDEF;
            m_pend = 0; m_ost = 0; m_bt = 0; m_oc = 0;
            return;
        end
        d     = (m_act == 0) ? 1 : m_act;
        wrap  = en && !sync_clr && (m_os >= d - 1);
        apply = wrap || sync_clr || !en;
        if (apply) begin
            m_act  = div_wr ? int'(div_val) : m_shd;
            if (div_wr) m_shd = int'(div_val);
            m_pend = 0;
        end else if (div_wr) begin
            m_shd  = int'(div_val);
            m_pend = 1;
        end
        if (sync_clr) begin
            m_os = 0; m_ph = 0; m_ost = 0; m_bt = 0; m_oc = 0;
        end else if (!en) begin
            m_ost = 0; m_bt = 0;
        end else if (wrap) begin
            m_bt  = (m_ph == OS - 1);
            m_ph  = (m_ph + 1) % OS;
            m_os  = 0;
            m_ost = 1;
            m_oc  = (m_ph >= OS / 2);
        end else begin
            m_os  = m_os + 1;
            m_ost = 0; m_bt = 0;
            m_oc  = (m_ph >= OS / 2);
        end
    endtask

    task automatic step(input bit r, input bit e, input bit c, input bit w,
                        input logic [15:0] v);
        rst = r; en = e; sync_clr = c; div_wr = w; div_val = v;
        model_step();
        exp_q.push_back({m_ost, m_bt, m_oc, m_pend});
        @(posedge inp_clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, '0);
    endtask

    // Monitor: pops the expected vector for each edge and compares.
    int cyc = 0, last_os = -1, last_bt = -1;
    always @(negedge inp_clk) begin
        logic [3:0] e;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({os_tick, baud_tick, out_clk, div_pending} !== e) begin
                n_err++;
                $display("FAIL %s cycle %0d: {os,baud,clk,pend} got %b want %b",
                         phase, cyc, {os_tick, baud_tick, out_clk, div_pending}, e);
            end
        end
        // Independent period checks at the default rate.
        if (phase == "default") begin
            if (os_tick === 1'b1) begin
                if (last_os >= 0) begin
                    n_cmp++;
                    if (cyc - last_os != DDEF) begin
                        n_err++;
                        $display("FAIL os_period: got %0d want %0d", cyc - last_os, DDEF);
                    end
                end
                last_os = cyc;
            end
            if (baud_tick === 1'b1) begin
                if (last_bt >= 0) begin
                    n_cmp++;
                    if (cyc - last_bt != DDEF * OS) begin
                        n_err++;
                        $display("FAIL baud_period: got %0d want %0d", cyc - last_bt,
                                 DDEF * OS);
                    end
                end
                last_bt = cyc;
            end
        end
    end

    initial begin
        int d;
        // Reset with en high: all outputs must stay 0.
        repeat (3) step(1, 1, 0, 0, '0);

        phase = "default";
        run(1000);

        phase = "update_mid";
        for (int i = 0; i < 100 && m_os != 10; i++) run(1);
        step(0, 1, 0, 1, 16'd4);
        run(120);

        phase = "write_on_wrap";
        d = (m_act == 0) ? 1 : m_act;
        for (int i = 0; i < 100 && m_os != d - 1; i++) run(1);
        step(0, 1, 0, 1, 16'd7);
        run(120);

        phase = "degenerate";
        step(0, 1, 0, 1, 16'd0);
        run(40);
        step(0, 1, 0, 1, 16'd1);
        run(40);

        phase = "enable_gate";
        step(0, 1, 0, 1, 16'd27);
        run(200);
        for (int i = 0; i < 50; i++) step(0, 0, 0, 0, '0);
        run(200);

        phase = "sync_clr";
        for (int i = 0; i < 1000 && m_ph != 11; i++) run(1);
        step(0, 1, 1, 0, '0);
        run(450);

        phase = "rst_mid";
        run(37);
        step(1, 1, 0, 0, '0);
        run(60);

        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 49) == 0, $urandom_range(0, 29) == 0,
                 16'($urandom_range(0, 12)));
        end
        phase = "drain";
        step(0, 1, 0, 0, '0);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge inp_clk);
        #1;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d pending entries want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/baud_gen.md
# baud_gen

Programmable baud-rate generator, the parametrised successor to the fixed-ratio `clockDiv`. It derives an oversample tick, a baud tick and a square-wave baud clock from `inp_clk` using a runtime-loadable divisor. Divisor updates are glitch-free and take effect at a period boundary. A phase-clear input lets the UART receiver realign to a start-bit edge; the block sits between the system clock and the UART TX/RX engines.

## Interface
- `CNT_W`, 16: width of the divisor and the oversample counter.
- `OVERSAMPLE`, 16: oversample ticks per baud period. Power of two, ≥2.
- `DEFAULT_DIV`, 27: divisor loaded at reset. Must fit in `CNT_W` bits.

Ports:
- `inp_clk` in 1: system clock. The block has one clock; reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: count enable.
- `sync_clr` in 1: phase realign. Clears both counters.
- `div_wr` in 1: one-cycle write strobe for `div_val`.
- `div_val` in `CNT_W`: new divisor, in `inp_clk` cycles per oversample tick.
- `os_tick` out 1: one-cycle pulse per oversample period.
- `baud_tick` out 1: one-cycle pulse per baud period. Coincides with every `OVERSAMPLE`th `os_tick`.
- `out_clk` out 1: baud-rate square wave.
- `div_pending` out 1: a written divisor is waiting to be applied.

## Operation
- Registers:
  - `div_act`: active divisor.
  - `div_shd`: shadow divisor.
  - `os_cnt`: `CNT_W` bits.
  - `ph_cnt`: $clog2(`OVERSAMPLE`) bits.
- Effective divisor `d_eff` = max(`div_act`, 1). A `div_val` of 0 behaves as 1, giving `os_tick` every enabled cycle.
- Priority at each edge: `rst` > `sync_clr` > `en` counting.
- Reset values:
  - `os_cnt` = 0, `ph_cnt` = 0.
  - `os_tick`, `baud_tick`, `out_clk`, `div_pending` = 0.
  - `div_act` = `div_shd` = `DEFAULT_DIV`.
- `div_wr`: `div_shd` <= `div_val`, `div_pending` <= 1.
  - A later write before application overwrites the shadow (last write wins).
- Application of the shadow divisor: `div_act` <= `div_shd` and `div_pending` <= 0 at any edge that meets one of these:
  - an oversample wrap occurs;
  - `sync_clr` = 1;
  - `en` = 0.
- `div_wr` on the same edge as an application: `div_act` takes `div_val` directly and `div_pending` stays 0.
- Counting, when `en` = 1 and `sync_clr` = 0:
  - If `os_cnt` == `d_eff`−1 (oversample wrap): `os_cnt` <= 0, `os_tick` <= 1, `ph_cnt` <= `ph_cnt`+1 (wraps mod `OVERSAMPLE`).
  - On an oversample wrap with `ph_cnt` == `OVERSAMPLE`−1: `baud_tick` <= 1.
  - Otherwise: `os_cnt` <= `os_cnt`+1, and both ticks <= 0.
- `out_clk` <= (next `ph_cnt` ≥ `OVERSAMPLE`/2). It is low in the first half of each baud period and high in the second. Each `baud_tick` coincides with `out_clk` falling.
- `en` = 0: counters and `out_clk` hold; both ticks <= 0.
- `sync_clr` = 1: both counters <= 0, both ticks <= 0, `out_clk` <= 0.
  - Counting resumes on the next edge, so the first `os_tick` follows `d_eff` edges after `sync_clr` deasserts.
- Reducing the divisor below the current `os_cnt` is safe, because application happens only at wrap, clear or idle.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- `os_tick` period: `d_eff` cycles.
- `baud_tick` period: `d_eff`·`OVERSAMPLE` cycles.
- First `os_tick`: on the `d_eff`th enabled edge after reset release.
- Divisor change latency: at most `d_eff` cycles when enabled; the next edge when idle.
- `div_pending` rises on the edge after `div_wr`.

## Structure
- `uart_pkg` holds the shared constants: `UART_CNT_W`, `UART_OVERSAMPLE`, `UART_DEFAULT_DIV` (100 MHz / 16 / 230400 ≈ 27).
- One sub-module, `tick_counter #(W)`, with inputs `inc`, `clr`, `max` and outputs `cnt`, `wrap`. It is instantiated twice:
  - oversample counter: `max` = `d_eff`−1;
  - phase counter: `max` = `OVERSAMPLE`−1, `inc` = oversample wrap.

## Test plan
- **Reset and default rate:** reset, `en`=1, defaults (27/16).
  - `os_tick` every 27 cycles.
  - `baud_tick` every 432 cycles.
  - `out_clk` low for 216 cycles, then high for 216; all outputs 0 during `rst`.
- **Divisor update mid-period:** `div_val`=4 written when `os_cnt`=10 (divisor 27).
  - `div_pending`=1 until the next wrap (at most 17 cycles), then clears.
  - From then on `os_tick` every 4 cycles.
- **Simultaneous write and wrap:** `div_wr` on the wrap edge.
  - New divisor active immediately; `div_pending` never rises.
- **Degenerate divisors:** `div_val`=0, then 1.
  - Both give `os_tick`=1 every enabled cycle.
  - `baud_tick` every 16 cycles.
- **Enable gating:** `en` dropped for 50 cycles mid-period.
  - Ticks are 0 throughout; `out_clk` and counters hold.
  - Counting resumes exactly where it stopped.
- **Phase realign:** `sync_clr` pulsed at phase 11.
  - `out_clk`=0 on the next edge.
  - Next `baud_tick` arrives exactly 432 cycles after `sync_clr` deasserts.
  - Compare also `rst` asserted mid-period: the block returns to the full reset state.
